// File: rtl/decode_issue_pkg.sv
// datatypes: instruction-type encodings, RV32 opcodes and the decoded record shared by decode and execute.
package datatypes;
   localparam int XLEN = 32;
   typedef enum logic [2:0] {
      INSTR_R = 3'd0,
      INSTR_I = 3'd1,
      INSTR_S = 3'd2,
      INSTR_B = 3'd3,
      INSTR_U = 3'd4,
      INSTR_J = 3'd5,
      INSTR_X = 3'b111
   } instr_t;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      instr_t          itype;
      logic [31:0]     imm;
      logic            illegal;
   } decoded_t;
   localparam decoded_t DECODED_RST = '{instr: 32'd0, pc: '0, itype: INSTR_X, imm: 32'd0, illegal: 1'b0};
endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch-side and execute-side handshakes of the decode stage, plus flush.
interface decode_issue_if;
   import datatypes::*;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   instr_t          out_type;
   logic [31:0]     out_imm;
   logic            out_illegal;
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_type, out_imm, out_illegal
   );
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_type, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_issue_imm_gen.sv
// imm_gen_32: RV32 immediate assembly from instr[31:7] and the classified type; R yields the shamt/rs2 field.
module imm_gen_32
   import datatypes::*;
(
   input  logic [31:7] instr,
   input  instr_t      itype,
   output logic [31:0] imm
);
   always_comb
      imm = (itype == INSTR_R) ? {27'd0, instr[24:20]} :
            (itype == INSTR_I) ? {{20{instr[31]}}, instr[31:20]} :
            (itype == INSTR_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            (itype == INSTR_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
            (itype == INSTR_U) ? {instr[31:12], 12'd0} :
            (itype == INSTR_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
            32'd0;
endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32 decode-stage register with stall, flush and illegal-opcode detection.
// DECODE_SKID_EN swaps the single register for a 2-entry skid buffer with a registered in_ready.
module decode_issue
   import datatypes::*;
(
   input logic           clk,
   input logic           rst_n,
   decode_issue_if.slave bus
);
   function automatic instr_t classify(input logic [31:0] w);
      case (w[6:0])
         OPC_OP:                                      return INSTR_R;
         OPC_OPIMM:                                   return (w[13:12] == 2'b01) ? INSTR_R : INSTR_I;
         OPC_LOAD, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM: return INSTR_I;
         OPC_STORE:                                   return INSTR_S;
         OPC_BRANCH:                                  return INSTR_B;
         OPC_LUI, OPC_AUIPC:                          return INSTR_U;
         OPC_JAL:                                     return INSTR_J;
         default:                                     return INSTR_X;
      endcase
   endfunction
   instr_t      typ;
   logic [31:0] imm;
   decoded_t    d, q;
   assign typ = classify(bus.in_instr);
   imm_gen_32 u_imm (.instr(bus.in_instr[31:7]), .itype(typ), .imm(imm));
   assign d = '{instr: bus.in_instr, pc: bus.in_pc, itype: typ, imm: imm, illegal: typ == INSTR_X};
`ifdef DECODE_SKID_EN
   logic [1:0] cnt, nxt;
   logic       rdy, push, pop;
   decoded_t   q1;
   assign push = bus.in_valid && rdy && !bus.flush;
   assign pop  = bus.out_valid && bus.out_ready && !bus.flush;
   assign nxt  = cnt + 2'(push) - 2'(pop);
   // q is the head entry seen by execute; q1 only fills when the head is stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= 2'd0;
         rdy <= 1'b1;
         q   <= DECODED_RST;
         q1  <= DECODED_RST;
      end else if (bus.flush) begin
         cnt <= 2'd0;
         rdy <= 1'b1;
      end else begin
         cnt <= nxt;
         rdy <= nxt != 2'd2;
         if (pop && cnt == 2'd2) q <= q1;
         else if (push && (cnt == 2'd0 || pop)) q <= d;
         if (push && !pop && cnt == 2'd1) q1 <= d;
      end
   assign bus.in_ready  = rdy;
   assign bus.out_valid = cnt != 2'd0;
`else
   logic vld;
   assign bus.in_ready = !bus.flush && (!vld || bus.out_ready);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld <= 1'b0;
         q   <= DECODED_RST;
      end else if (bus.flush) begin
         vld <= 1'b0;
      end else if (bus.in_ready) begin
         vld <= bus.in_valid;
         if (bus.in_valid) q <= d;
      end
   assign bus.out_valid = vld;
`endif
   assign bus.out_instr   = q.instr;
   assign bus.out_pc      = q.pc;
   assign bus.out_type    = q.itype;
   assign bus.out_imm     = q.imm;
   assign bus.out_illegal = q.illegal;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed self-checking bench for decode_issue.
module tb_decode_issue;
   import datatypes::*;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   decode_issue_if bus();
   decode_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   logic [31:0] s_instr[4];
   logic [31:0] s_imm[4];
   instr_t      s_type[4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
      n_cmp++; if (bus.out_instr !== 32'd0) begin n_err++; $display("FAIL rst_instr got %h exp 0", bus.out_instr); end
      n_cmp++; if (bus.out_pc !== 32'd0) begin n_err++; $display("FAIL rst_pc got %h exp 0", bus.out_pc); end
      n_cmp++; if (bus.out_type !== INSTR_X) begin n_err++; $display("FAIL rst_type got %0d exp 7", bus.out_type); end
      n_cmp++; if (bus.out_imm !== 32'd0) begin n_err++; $display("FAIL rst_imm got %h exp 0", bus.out_imm); end
      n_cmp++; if (bus.out_illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %b exp 0", bus.out_illegal); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_addi();
      bus.in_valid = 1'b1; bus.in_instr = 32'hFFF00093; bus.in_pc = 32'h100;
      step();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b exp 1", bus.out_valid); end
      n_cmp++; if (bus.out_type !== INSTR_I) begin n_err++; $display("FAIL addi_type got %0d exp 1", bus.out_type); end
      n_cmp++; if (bus.out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm got %h exp ffffffff", bus.out_imm); end
      n_cmp++; if (bus.out_pc !== 32'h100) begin n_err++; $display("FAIL addi_pc got %h exp 100", bus.out_pc); end
      n_cmp++; if (bus.out_illegal !== 1'b0) begin n_err++; $display("FAIL addi_illegal got %b exp 0", bus.out_illegal); end
      n_cmp++; if (bus.out_instr !== 32'hFFF00093) begin n_err++; $display("FAIL addi_instr got %h exp fff00093", bus.out_instr); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.in_instr = s_instr[i]; bus.in_pc = 32'h200 + 32'(4 * i);
         #1;
         n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready); end
         step();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid); end
         n_cmp++; if (bus.out_type !== s_type[i]) begin n_err++; $display("FAIL stream_type[%0d] got %0d exp %0d", i, bus.out_type, s_type[i]); end
         n_cmp++; if (bus.out_imm !== s_imm[i]) begin n_err++; $display("FAIL stream_imm[%0d] got %h exp %h", i, bus.out_imm, s_imm[i]); end
         n_cmp++; if (bus.out_pc !== 32'h200 + 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.out_pc, 32'h200 + 32'(4 * i)); end
      end
      bus.in_valid = 1'b0;
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_end got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_stall();
      int  fi = 0;
      int  oi = 0;
      logic exp_rdy;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 30 && oi < 4; c++) begin
         if (c == 4) bus.out_ready = 1'b1;
         bus.in_valid = fi < 4;
         bus.in_instr = s_instr[fi % 4];
         bus.in_pc = 32'h300 + 32'(4 * fi);
         #1;
         if (c >= 1 && c <= 3) begin
`ifdef DECODE_SKID_EN
            exp_rdy = (c == 1);
`else
            exp_rdy = 1'b0;
`endif
            n_cmp++; if (bus.in_ready !== exp_rdy) begin n_err++; $display("FAIL stall_ready[%0d] got %b exp %b", c, bus.in_ready, exp_rdy); end
            n_cmp++; if (bus.out_instr !== s_instr[0] || bus.out_pc !== 32'h300 || bus.out_valid !== 1'b1)
               begin n_err++; $display("FAIL stall_hold[%0d] got %h/%h/%b exp %h/300/1", c, bus.out_instr, bus.out_pc, bus.out_valid, s_instr[0]); end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_cmp++; if (bus.out_instr !== s_instr[oi] || bus.out_pc !== 32'h300 + 32'(4 * oi))
               begin n_err++; $display("FAIL stall_order[%0d] got %h/%h exp %h/%h", oi, bus.out_instr, bus.out_pc, s_instr[oi], 32'h300 + 32'(4 * oi)); end
            oi++;
         end
         if (bus.in_valid && bus.in_ready) fi++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      n_cmp++; if (oi !== 4) begin n_err++; $display("FAIL stall_count got %0d exp 4", oi); end
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      bus.in_valid = 1'b1; bus.in_instr = 32'h00000000; bus.in_pc = 32'h400;
      step();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got %b exp 1", bus.out_valid); end
      n_cmp++; if (bus.out_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b exp 1", bus.out_illegal); end
      n_cmp++; if (bus.out_type !== INSTR_X) begin n_err++; $display("FAIL ill_type got %0d exp 7", bus.out_type); end
      n_cmp++; if (bus.out_imm !== 32'd0) begin n_err++; $display("FAIL ill_imm got %h exp 0", bus.out_imm); end
      n_cmp++; if (bus.out_pc !== 32'h400) begin n_err++; $display("FAIL ill_pc got %h exp 400", bus.out_pc); end
      step();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = 32'h12345037; bus.in_pc = 32'h500;
      step();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre got %b exp 1", bus.out_valid); end
      bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'h0040006F; bus.in_pc = 32'h504;
`ifndef DECODE_SKID_EN
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b exp 0", bus.in_ready); end
`endif
      step();
      bus.flush = 1'b0; bus.in_instr = 32'h4030D093; bus.in_pc = 32'h508;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got %b exp 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_reready got %b exp 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h4030D093 || bus.out_pc !== 32'h508)
         begin n_err++; $display("FAIL flush_next got %b/%h/%h exp 1/4030d093/508", bus.out_valid, bus.out_instr, bus.out_pc); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_end got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = 32'h0020A423; bus.in_pc = 32'h600;
      step();
      bus.in_instr = 32'h12345037; bus.in_pc = 32'h604;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
      n_cmp++; if (bus.out_instr !== 32'd0) begin n_err++; $display("FAIL rstmid_instr got %h exp 0", bus.out_instr); end
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1; bus.in_instr = 32'hFFF00093; bus.in_pc = 32'h700;
      step();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF00093 || bus.out_pc !== 32'h700)
         begin n_err++; $display("FAIL rstmid_first got %b/%h/%h exp 1/fff00093/700", bus.out_valid, bus.out_instr, bus.out_pc); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_end got %b exp 0", bus.out_valid); end
   endtask

   initial begin
      s_instr[0] = 32'h12345037; s_type[0] = INSTR_U; s_imm[0] = 32'h12345000;
      s_instr[1] = 32'h0040006F; s_type[1] = INSTR_J; s_imm[1] = 32'h00000004;
      s_instr[2] = 32'h4030D093; s_type[2] = INSTR_R; s_imm[2] = 32'h00000003;
      s_instr[3] = 32'h0020A423; s_type[3] = INSTR_S; s_imm[3] = 32'h00000008;
      test_reset();
      test_addi();
      test_stream();
      test_stall();
      test_illegal();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-stage pipeline register for the RV32 core, sitting between fetch and execute. It accepts fetched instruction/PC pairs over a valid/ready handshake and classifies the opcode into the shared `INSTR_*` type. It drives the existing `imm_gen_32` combinationally to produce the immediate, then registers instruction, PC, type, immediate and an illegal flag toward execute. It owns stall (backpressure), flush and illegal-opcode detection for the decode stage.

## Interface
- `XLEN`, 32, PC width.
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  decode can accept this cycle.
- `in_instr`  in  32  fetched instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `flush`  in  1  kill all held instructions (branch or trap redirect).
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  execute accepts this cycle.
- `out_instr`  out  32  registered instruction.
- `out_pc`  out  XLEN  registered PC.
- `out_type`  out  3  `INSTR_R/I/S/B/U/J`, or `INSTR_X` (3'b111) when illegal.
- `out_imm`  out  32  registered immediate.
- `out_illegal`  out  1  opcode not recognised.

## Operation
- Opcode classification (`in_instr[6:0]`):
  - OP 0110011 → R.
  - OP-IMM 0010011 → I, except funct3 001/101 (SLLI/SRLI/SRAI) → R, so the immediate is `{27'b0,shamt}`.
  - LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111, AUIPC 0010111 → U.
  - JAL 1101111 → J.
- Any other opcode, including `in_instr[1:0]` != 2'b11: type `INSTR_X`, illegal=1, imm=0. The instruction still flows so execute can raise the trap.
- Immediate is computed from `in_instr` before the register and captured with the other fields. There is no combinational path from `in_instr` to the outputs.
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- While `out_valid && !out_ready`, all `out_*` hold stable.
- `in_ready = !flush && (!out_valid || out_ready)`, which allows same-cycle drain and refill.
- Flush:
  - Clears `out_valid` at the next edge.
  - Overrides any simultaneous input acceptance; the fetch beat on a flush cycle is dropped.
  - Overrides any simultaneous output handshake; execute must ignore `out_valid` during a flush cycle.

## Timing
- Latency 1 cycle: accepted at edge N → `out_valid` high after edge N.
- Throughput 1 instruction/cycle with `out_ready` held high.
- Reset values:
  - Asserted: `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_type`=`INSTR_X`, `out_imm`=0, `out_illegal`=0.
  - `in_ready` is 1 while reset is asserted and `flush`=0.
- Reset asserted mid-transfer discards the held instruction immediately (asynchronous). The first accept is possible on the first edge after deassertion.
- A flush and reset asserted together give the reset result.

## Configuration
- `DECODE_SKID_EN` defined:
  - A 2-entry skid buffer replaces the single register.
  - `in_ready` is a flop output (1 while fewer than 2 entries are held) and is not combinational on `out_ready`.
  - Latency stays 1 cycle when empty; throughput stays 1/cycle.
  - Flush empties both entries.
- Undefined: single register; `in_ready` is combinational as above.
- Both builds are transfer-equivalent.

## Structure
- Package `datatypes`:
  - Holds the `INSTR_*` encodings and `INSTR_X`.
  - Add opcode constants `OPC_OP`, `OPC_OPIMM`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`, `OPC_LUI`, `OPC_AUIPC`, `OPC_MISCMEM`, `OPC_SYSTEM`.
  - Add a packed struct `decoded_t` holding instr, pc, type, imm and illegal.
- Sub-module: instantiate the existing `imm_gen_32`, fed `in_instr[31:7]` and the classified type. Opcode classification stays local to this block.

## Test plan
- `addi x1,x0,-1` = 0xFFF00093, PC 0x100 → next cycle `out_type`=I, `out_imm`=0xFFFFFFFF, `out_pc`=0x100, illegal=0.
- Stream of 4 instructions, each with its own expected result checked in order, no bubbles:
  - `lui` 0x12345037 → U, imm 0x12345000.
  - `jal x0,+4` 0x0040006F → J, imm 0x00000004.
  - `srai x1,x1,3` 0x4030D093 → R, imm 0x00000003.
  - `sw x2,8(x1)` 0x0020A423 → S, imm 0x00000008.
- `out_ready` low for 3 cycles with `in_valid` high:
  - Outputs are stable throughout.
  - `in_ready`=0 (single-register build) or goes low after 2 accepts (skid build).
  - No beat is lost or duplicated after release.
- 0x00000000 → `out_illegal`=1, `out_type`=`INSTR_X`, imm 0.
- Flush with `out_valid`=1 and `in_valid`=1 → `out_valid`=0 next cycle and the fetch beat on the flush cycle is dropped; the next beat is accepted 1 cycle later.
- `rst_n` asserted mid-stream while stalled → `out_valid`=0 immediately; the first post-reset instruction appears 1 cycle after its accept.
